sysid_checker: RTL and testbench
================================

# sysid_checker

Boot-time system-ID verifier sitting directly upstream of the system-ID Avalon-MM slave in the SoC. After reset, or on request, it issues two Avalon-MM reads: word 0 (system ID) and word 1 (build timestamp). It compares both against build-time parameters and presents registered pass/fail flags and the captured values to the status/LED logic. Per-read timeout and bounded retries keep a dead or mis-mapped slave from hanging the check.

## Interface

- EXPECTED_ID, 32'h0000_0000, value required at word 0
- EXPECTED_TS, 32'h6377_FA27, value required at word 1
- START_DELAY, 16, clocks after reset deassertion before the automatic check starts (≥1)
- TIMEOUT, 255, max clocks a read may be held by waitrequest (≥1, ≤ 2^16-1)
- MAX_RETRY, 3, extra attempts per word after a timeout (0..15)

Ports:

- clock, in, 1, single system clock, all logic rising-edge
- reset_n, in, 1, asynchronous active-low reset
- start, in, 1, one-cycle pulse re-runs the check; ignored while busy
- avm_address, out, 1, word address to sysid slave (0 = ID, 1 = timestamp)
- avm_read, out, 1, Avalon read strobe
- avm_readdata, in, 32, read data, valid when avm_read=1 and avm_waitrequest=0
- avm_waitrequest, in, 1, slave stall; tie 0 for zero-wait slaves
- busy, out, 1, check in progress
- done, out, 1, check finished (pass or fail), sticky until next run
- id_ok, out, 1, captured ID == EXPECTED_ID
- ts_ok, out, 1, captured timestamp == EXPECTED_TS
- timeout_err, out, 1, a word exhausted all retries
- id_value, out, 32, last captured ID
- ts_value, out, 32, last captured timestamp

## Operation

- States: RESET_WAIT, IDLE, RD_ID, RD_TS, DONE.
- Reset values: state RESET_WAIT; delay counter 0; avm_read 0; avm_address 0; busy 1; done, id_ok, ts_ok, timeout_err 0; id_value, ts_value 0.
- RESET_WAIT: count START_DELAY clocks, then go to RD_ID. start is ignored.
- RD_ID: drive avm_address=0, avm_read=1. On the cycle with avm_waitrequest=0, capture avm_readdata into id_value and go to RD_TS.
- RD_TS: drive avm_address=1, avm_read=1. On accept, capture into ts_value and go to DONE.
- Timeout: a 16-bit wait counter clears on entry to each read and increments each cycle waitrequest=1.
  - When it reaches TIMEOUT with the retry count < MAX_RETRY: deassert avm_read for exactly one cycle, increment the retry count, and reissue the same address.
  - When retries are exhausted: set timeout_err and go to DONE without reading further words; the unread value keeps its prior contents and its ok flag is 0.
  - The retry count resets per word.
- DONE (entry cycle): done=1, busy=0, id_ok and ts_ok evaluated from the captured values (a word not read this run gives ok=0). Next state IDLE.
- IDLE: hold all flags. A start pulse sets done, id_ok, ts_ok and timeout_err to 0, sets busy to 1, and goes to RD_ID (no START_DELAY).
- start arriving in RESET_WAIT, RD_ID, RD_TS or DONE is dropped, not queued.
- All comparisons are full 32-bit equality; no masking.

## Timing

- Zero-wait slave: avm_read is high for exactly 2 consecutive cycles (address 0, then 1).
- Auto-check: done rises START_DELAY+3 clocks after reset_n deassertion, counted from the first rising edge with reset_n high.
- From a start pulse in IDLE: avm_read rises the next cycle; done rises 3 cycles after start.
- avm_address and avm_read are registered outputs, stable for the whole stall.
- Retry gap: avm_read low exactly 1 cycle between attempts.
- All status outputs are registered.
- Asserting reset_n low mid-read drops avm_read and all outputs to their reset values immediately (asynchronously). On release, the sequence restarts from RESET_WAIT.

## Test plan

- Zero-wait slave returning 0 at word 0 and 0x6377FA27 at word 1, defaults -> done at cycle START_DELAY+3; id_ok=1, ts_ok=1, timeout_err=0; ts_value=0x6377FA27.
- Word 1 returns 0x6377FA28 -> done=1, id_ok=1, ts_ok=0, ts_value=0x6377FA28.
- waitrequest held high for 3 cycles on word 0, then released -> single read, no retry; id captured; done 3 cycles later than the zero-wait case.
- waitrequest stuck high, TIMEOUT=4, MAX_RETRY=2 -> 3 attempts on address 0, each 4 cycles with a 1-cycle read-low gap; then timeout_err=1, id_ok=0, ts_ok=0, address 1 never driven.
- After a pass, change word 1 to 0x1 and pulse start -> flags clear the next cycle; done re-asserts 3 cycles after start with ts_ok=0. A second start during busy has no effect.
- Assert reset_n low during an RD_TS stall -> avm_read=0 and all outputs at reset values in the same cycle; after release, a full re-check completes with a pass.

Source files
------------

// File: rtl/sysid_checker.sv
// sysid_checker: reads system ID and build timestamp over Avalon-MM after reset or on start,
// compares them against build-time constants, with per-read timeout and bounded retries.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS = 32'h6377_FA27,
  parameter int START_DELAY = 16,
  parameter int TIMEOUT = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);
  localparam int DW = $clog2(START_DELAY + 1);
  typedef enum logic [2:0] {RESET_WAIT, IDLE, RD_ID, RD_TS, DONE} state_t;
  state_t state, state_n;
  logic [DW-1:0] dcnt;
  logic [15:0] wcnt;
  logic [3:0] rcnt;
  logic accept, stall_to, retry, give_up, rerun;
  assign accept = avm_read && !avm_waitrequest;
  assign stall_to = avm_read && avm_waitrequest && wcnt == 16'(TIMEOUT - 1);
  assign retry = stall_to && rcnt != 4'(MAX_RETRY);
  assign give_up = stall_to && !retry;
  assign rerun = state == IDLE && start;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= RESET_WAIT;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      RESET_WAIT: state_n = dcnt == DW'(START_DELAY) ? RD_ID : RESET_WAIT;
      IDLE:       state_n = start ? RD_ID : IDLE;
      RD_ID:      state_n = accept ? RD_TS : give_up ? DONE : RD_ID;
      RD_TS:      state_n = accept || give_up ? DONE : RD_TS;
      DONE:       state_n = IDLE;
      default:    state_n = RESET_WAIT;
    endcase
  end
  // Outputs are registered from the next state so they line up with it; a retry drops read for one cycle.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      dcnt <= '0;
      wcnt <= '0;
      rcnt <= '0;
      avm_read <= 1'b0;
      avm_address <= 1'b0;
      busy <= 1'b1;
      done <= 1'b0;
      id_ok <= 1'b0;
      ts_ok <= 1'b0;
      timeout_err <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      dcnt <= state == RESET_WAIT && dcnt != DW'(START_DELAY) ? dcnt + DW'(1) : dcnt;
      wcnt <= avm_read && avm_waitrequest && !stall_to ? wcnt + 16'd1 : 16'd0;
      rcnt <= retry ? rcnt + 4'd1 : state_n != state ? 4'd0 : rcnt;
      avm_read <= (state_n == RD_ID || state_n == RD_TS) && !retry;
      avm_address <= state_n == RD_TS;
      busy <= state_n != IDLE && state_n != DONE;
      done <= state_n == DONE || (done && !rerun);
      id_ok <= state_n == DONE ? state == RD_TS && id_value == EXPECTED_ID : id_ok && !rerun;
      ts_ok <= state_n == DONE ? state == RD_TS && accept && avm_readdata == EXPECTED_TS : ts_ok && !rerun;
      timeout_err <= give_up || (timeout_err && !rerun);
      if (state == RD_ID && accept) id_value <= avm_readdata;
      if (state == RD_TS && accept) ts_value <= avm_readdata;
    end
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: scoreboard bench with a stalling Avalon slave model and an attempt-level reference model.
module tb_sysid_checker;
  localparam int SD = 16, TO = 4, MR = 2;
  localparam logic [31:0] EID = 32'h0000_0000, ETS = 32'h6377_FA27;
  logic clock = 1'b0, reset_n, start = 1'b0;
  logic avm_address, avm_read, avm_waitrequest = 1'b0;
  logic busy, done, id_ok, ts_ok, timeout_err;
  logic [31:0] avm_readdata = '0, id_value, ts_value;
  always #5 clock = ~clock;

  sysid_checker #(.EXPECTED_ID(EID), .EXPECTED_TS(ETS), .START_DELAY(SD), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout_err(timeout_err),
    .id_value(id_value), .ts_value(ts_value)
  );

  typedef struct {
    logic idok, tsok, terr;
    logic [31:0] idv, tsv;
    int at, a0, a1;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int total = 0, bad = 0, cyc = 0;
  int q0[$], q1[$];
  int att[2] = '{0, 0};
  logic [31:0] w_id = '0, w_ts = ETS, m_idv = '0, m_tsv = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Slave: each new attempt (read rising or address change) takes its stall length from the plan queue.
  int stall = 0;
  logic prev_rd = 1'b0, prev_addr = 1'b0;
  always @(negedge clock) begin
    if (avm_read && (!prev_rd || prev_addr != avm_address)) begin
      att[avm_address] = att[avm_address] + 1;
      if (avm_address) stall = q1.size() > 0 ? q1.pop_front() : 0;
      else stall = q0.size() > 0 ? q0.pop_front() : 0;
    end else if (stall > 0) stall = stall - 1;
    prev_rd = avm_read;
    prev_addr = avm_address;
    avm_waitrequest = avm_read && stall > 0;
    avm_readdata = avm_address ? w_ts : w_id;
  end

  // Cycles one word occupies from its first read cycle until the next word starts or the check gives up.
  function automatic int word_cycles(input int st[$], output logic got, output int n);
    int c = 0;
    got = 1'b0;
    n = 0;
    for (int a = 0; a <= MR; a++) begin
      int s = a < st.size() ? st[a] : 0;
      n++;
      if (s < TO) begin
        got = 1'b1;
        return c + s + 1;
      end
      c += a < MR ? TO + 1 : TO;
    end
    return c;
  endfunction

  task automatic plan_run(input int s0[$], input int s1[$], input logic [31:0] id, input logic [31:0] ts, input int t0);
    exp_t x;
    int c0, c1, a0, a1;
    logic r0, r1;
    q0 = s0;
    q1 = s1;
    w_id = id;
    w_ts = ts;
    c0 = word_cycles(s0, r0, a0);
    c1 = 0; r1 = 1'b0; a1 = 0;
    if (r0) c1 = word_cycles(s1, r1, a1);
    if (r0) m_idv = id;
    if (r1) m_tsv = ts;
    x.idok = r0 && id == EID;
    x.tsok = r1 && ts == ETS;
    x.terr = !(r0 && r1);
    x.idv = m_idv;
    x.tsv = m_tsv;
    x.at = t0 + c0 + c1;
    x.a0 = att[0] + a0;
    x.a1 = att[1] + a1;
    sb.push_back(x);
  endtask

  logic pd = 1'b0;
  always @(negedge clock) begin
    if (done && !pd) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done rise at cycle %0d required none", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.at);
        chk("id_ok", id_ok, e.idok);
        chk("ts_ok", ts_ok, e.tsok);
        chk("timeout_err", timeout_err, e.terr);
        chk("id_value", id_value, e.idv);
        chk("ts_value", ts_value, e.tsv);
        chk("busy_done", busy, 1'b0);
        chk("attempts_w0", att[0], e.a0);
        chk("attempts_w1", att[1], e.a1);
      end
    end
    pd = done;
  end

  task automatic drain(input int budget);
    int i = 0;
    while (sb.size() > 0 && i < budget) begin
      @(negedge clock);
      i++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic chk_reset();
    chk("rst_read", avm_read, 1'b0);
    chk("rst_addr", avm_address, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_flags", {28'd0, done, id_ok, ts_ok, timeout_err}, 32'd0);
    chk("rst_id", id_value, 32'd0);
    chk("rst_ts", ts_value, 32'd0);
  endtask

  task automatic reset_run(input int s0[$], input int s1[$], input logic [31:0] id, input logic [31:0] ts);
    @(negedge clock);
    plan_run(s0, s1, id, ts, cyc + 1 + SD);
    reset_n = 1'b1;
    drain(400);
  endtask

  task automatic start_run(input int s0[$], input int s1[$], input logic [31:0] id, input logic [31:0] ts, input bit dup);
    @(negedge clock);
    plan_run(s0, s1, id, ts, cyc + 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("clr_done", done, 1'b0);
    chk("clr_flags", {29'd0, id_ok, ts_ok, timeout_err}, 32'd0);
    chk("run_busy", busy, 1'b1);
    chk("read_rise", avm_read, 1'b1);
    if (dup) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    drain(400);
  endtask

  function automatic int rs();
    return $urandom_range(0, 7) == 0 ? 1000 : int'($urandom_range(0, 5));
  endfunction

  initial begin
    int none[$], w3[$], stuck[$], s0[$], s1[$];
    logic [31:0] id, ts;
    w3.push_back(3);
    repeat (3) stuck.push_back(1000);
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1 chk_reset();
    repeat (3) @(negedge clock);
    reset_run(none, none, EID, ETS);
    start_run(none, none, EID, 32'h6377_FA28, 1'b0);
    start_run(w3, none, EID, ETS, 1'b0);
    start_run(stuck, none, EID, ETS, 1'b0);
    start_run(none, none, EID, ETS, 1'b0);
    start_run(none, none, EID, 32'h0000_0001, 1'b1);
    // A start landing in the DONE cycle must be dropped.
    @(negedge clock);
    plan_run(none, none, EID, ETS, cyc + 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    chk("done_drop", done, 1'b1);
    chk("busy_drop", busy, 1'b0);
    chk("sb_empty", sb.size(), 32'd0);
    for (int r = 0; r < 25; r++) begin
      s0.delete();
      s1.delete();
      for (int a = 0; a < 3; a++) begin
        s0.push_back(rs());
        s1.push_back(rs());
      end
      id = $urandom_range(0, 1) != 0 ? EID : $urandom;
      ts = $urandom_range(0, 1) != 0 ? ETS : $urandom;
      start_run(s0, s1, id, ts, $urandom_range(0, 1) != 0);
    end
    // Reset during a stalled timestamp read.
    s1.delete();
    s1.push_back(1000);
    @(negedge clock);
    plan_run(none, s1, EID, ETS, cyc + 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 20 && !(avm_read && avm_address); i++) @(negedge clock);
    chk("ts_stall", {31'd0, avm_read && avm_address}, 32'd1);
    #2 reset_n = 1'b0;
    #1 chk_reset();
    sb.delete();
    m_idv = '0;
    m_tsv = '0;
    repeat (3) @(negedge clock);
    reset_run(none, none, EID, ETS);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish by cycle %0d required finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule
